tri_query_tx: RTL and testbench

- Initiator/driver for the pipelined point-in-triangle checker (signP).
- Accepts triangle-vertex and query-point commands over a valid/ready interface and serializes them onto signP's re/i1/i2 bus in the required order.
- Tags each new query, captures signP's s after the fixed pipeline latency, and returns {inside, x, y} through a result FIFO with backpressure.

---
 rtl/tri_pkg.sv | 14 +
 rtl/tri_res_fifo.sv | 38 +++
 rtl/tri_query_tx.sv | 118 +++++++++++
 tb/tb_tri_query_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// tri_pkg: shared sizes, command encoding, FSM states and result record for the signP driver
package tri_pkg;
  localparam int TRI_W = 11;
  localparam int TRI_LAT = 3;
  localparam int TRI_RDEPTH = 4;
  localparam logic KIND_VERTEX = 1'b0;
  localparam logic KIND_QUERY = 1'b1;
  typedef enum logic [2:0] {EMPTY, V1, V2, ARMED, BURST0, BURST1, BURST2, LOADED} state_t;
  typedef struct packed {
    logic in;
    logic [TRI_W-1:0] x;
    logic [TRI_W-1:0] y;
  } res_t;
endpackage

// File: rtl/tri_res_fifo.sv
// tri_res_fifo: circular result buffer whose head entry drives the outputs straight from storage
module tri_res_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign do_push = push && (count < CW'(DEPTH) || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      end
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/tri_query_tx.sv
// tri_query_tx: serializes vertex/query commands onto signP's re/i1/i2 bus and returns tagged results
module tri_query_tx import tri_pkg::*; #(
  parameter int W = TRI_W,
  parameter int LAT = TRI_LAT,
  parameter int RDEPTH = TRI_RDEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_kind,
  input  logic [W-1:0] cmd_x,
  input  logic [W-1:0] cmd_y,
  output logic         re,
  output logic [W-1:0] i1,
  output logic [W-1:0] i2,
  input  logic         s,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_in,
  output logic [W-1:0] res_x,
  output logic [W-1:0] res_y
);
  localparam int CW = $clog2(RDEPTH + 1);
  state_t state, state_n;
  logic [W-1:0] vx [3], vy [3];
  logic [W-1:0] qx, qy, nx, ny;
  logic [W-1:0] tx [LAT+1], ty [LAT+1];
  logic [LAT:0] tv;
  logic [CW-1:0] inflight, fcount;
  logic [1:0] vi, bi;
  logic acc, is_q, credit, issue, vbeat;
  assign acc = cmd_valid && cmd_ready;
  assign is_q = cmd_kind == KIND_QUERY;
  assign credit = (CW+1)'(inflight) + (CW+1)'(fcount) < (CW+1)'(RDEPTH);
  assign issue = state == BURST2 || (state == LOADED && acc && is_q);
  assign vbeat = (state == ARMED && acc) || state == BURST0 || state == BURST1;
  assign vi = state == V1 ? 2'd1 : state == V2 ? 2'd2 : 2'd0;
  assign bi = state == BURST0 ? 2'd1 : state == BURST1 ? 2'd2 : 2'd0;
  assign nx = state == BURST2 ? qx : cmd_x;
  assign ny = state == BURST2 ? qy : cmd_y;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= EMPTY;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (acc) state_n = V1;
      V1:      if (acc) state_n = V2;
      V2:      if (acc) state_n = ARMED;
      ARMED:   if (acc) state_n = BURST0;
      BURST0:  state_n = BURST1;
      BURST1:  state_n = BURST2;
      BURST2:  state_n = LOADED;
      LOADED:  if (acc && !is_q) state_n = V1;
      default: state_n = EMPTY;
    endcase
  end
  always_comb
    cmd_ready = state inside {EMPTY, V1, V2} ? !is_q :
                state == ARMED ? is_q && credit :
                state == LOADED ? !is_q || credit : 1'b0;
  // the tag pipe's last stage lines up with the edge where signP's s for that beat is valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      re <= 1'b1;
      i1 <= '0;
      i2 <= '0;
      qx <= '0;
      qy <= '0;
      tv <= '0;
      inflight <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
      for (int i = 0; i <= LAT; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
      end
    end else begin
      if (acc && !is_q) begin
        vx[vi] <= cmd_x;
        vy[vi] <= cmd_y;
      end
      if (acc && is_q) begin
        qx <= cmd_x;
        qy <= cmd_y;
      end
      if (vbeat) begin
        re <= 1'b0;
        i1 <= vx[bi];
        i2 <= vy[bi];
      end else if (issue) begin
        re <= 1'b1;
        i1 <= nx;
        i2 <= ny;
      end
      tv <= {tv[LAT-1:0], issue};
      tx[0] <= nx;
      ty[0] <= ny;
      for (int i = 1; i <= LAT; i++) begin
        tx[i] <= tx[i-1];
        ty[i] <= ty[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(tv[LAT]);
    end
  tri_res_fifo #(.DEPTH(RDEPTH), .DW(2 * W + 1)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tv[LAT]),
    .din({s, tx[LAT], ty[LAT]}),
    .pop(res_ready),
    .dout({res_in, res_x, res_y}),
    .valid(res_valid),
    .count(fcount)
  );
endmodule

// File: tb/tb_tri_query_tx.sv
// tb_tri_query_tx: directed checks of tri_query_tx against a behavioural signP with latency 3
module tb_tri_query_tx;
  logic clk = 1'b0, reset, cmd_valid, cmd_ready, cmd_kind, re, s, res_valid, res_ready, res_in;
  logic [10:0] cmd_x, cmd_y, i1, i2, res_x, res_y;
  int vectors = 0, miscompares = 0;
  int svx [3] = '{0, 0, 0};
  int svy [3] = '{0, 0, 0};
  int vcnt = 0;
  logic [2:0] sp = '0;
  bit ok;
  always #5 clk = ~clk;
  tri_query_tx dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .re(re), .i1(i1), .i2(i2), .s(s), .res_valid(res_valid),
    .res_ready(res_ready), .res_in(res_in), .res_x(res_x), .res_y(res_y)
  );
  function automatic int ed(int ax, int ay, int bx, int by, int px, int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction
  function automatic logic in_tri(int px, int py);
    int d0, d1, d2;
    d0 = ed(svx[0], svy[0], svx[1], svy[1], px, py);
    d1 = ed(svx[1], svy[1], svx[2], svy[2], px, py);
    d2 = ed(svx[2], svy[2], svx[0], svy[0], px, py);
    return (d0 > 0 && d1 > 0 && d2 > 0) || (d0 < 0 && d1 < 0 && d2 < 0);
  endfunction
  // signP stand-in: latches vertex beats, answers query beats three edges after capture
  always @(posedge clk) begin
    if (!re) begin
      svx[vcnt] <= int'(i1);
      svy[vcnt] <= int'(i2);
      vcnt <= vcnt == 2 ? 0 : vcnt + 1;
    end
    sp <= {sp[1:0], re && in_tri(int'(i1), int'(i2))};
  end
  assign s = sp[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic k, input int x, input int y, input int bound, output bit acc);
    cmd_valid = 1'b1;
    cmd_kind = k;
    cmd_x = 11'(x);
    cmd_y = 11'(y);
    acc = 1'b0;
    for (int n = 0; n < bound && !acc; n++) begin
      #1 acc = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_kind = 1'b0;
  endtask
  task automatic get(input logic e_in, input int ex, input int ey);
    for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
    chk("res_valid", res_valid, 1);
    if (res_valid) begin
      chk("res_in", res_in, e_in);
      chk("res_x", res_x, ex);
      chk("res_y", res_y, ey);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask
  task automatic bus(input string tag, input logic e_re, input int ex, input int ey);
    chk({tag, "_re"}, re, e_re);
    chk({tag, "_i1"}, i1, ex);
    chk({tag, "_i2"}, i2, ey);
  endtask
  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind = 1'b0;
    cmd_x = '0;
    cmd_y = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus("rst", 1, 0, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_in", res_in, 0);
    chk("rst_res_x", res_x, 0);
    chk("rst_res_y", res_y, 0);
    reset = 1'b1;
    @(negedge clk);
    send(1, 178, 168, 3, ok);
    chk("query_no_vertex", ok, 0);
    bus("idle0", 1, 0, 0);
    send(0, 10, 10, 3, ok);
    chk("vtx0", ok, 1);
    send(0, 200, 100, 3, ok);
    chk("vtx1", ok, 1);
    send(1, 178, 168, 3, ok);
    chk("query_two_vertex", ok, 0);
    bus("idle1", 1, 0, 0);
    send(0, 300, 300, 3, ok);
    chk("vtx2", ok, 1);
    send(1, 178, 168, 3, ok);
    chk("q1_acc", ok, 1);
    bus("burst_v0", 0, 10, 10);
    chk("burst_ready", cmd_ready, 0);
    @(negedge clk);
    bus("burst_v1", 0, 200, 100);
    @(negedge clk);
    bus("burst_v2", 0, 300, 300);
    @(negedge clk);
    bus("burst_q", 1, 178, 168);
    repeat (3) @(negedge clk);
    chk("q1_early", res_valid, 0);
    @(negedge clk);
    get(1, 178, 168);
    chk("res_valid_drop", res_valid, 0);
    send(1, 795, 22, 3, ok);
    chk("q2_acc", ok, 1);
    bus("q2_beat", 1, 795, 22);
    repeat (3) @(negedge clk);
    chk("q2_early", res_valid, 0);
    @(negedge clk);
    get(0, 795, 22);
    send(1, 178, 168, 3, ok);
    chk("bp_acc0", ok, 1);
    send(1, 795, 22, 3, ok);
    chk("bp_acc1", ok, 1);
    send(1, 200, 150, 3, ok);
    chk("bp_acc2", ok, 1);
    send(1, 50, 200, 3, ok);
    chk("bp_acc3", ok, 1);
    send(1, 260, 240, 8, ok);
    chk("bp_credit_block", ok, 0);
    get(1, 178, 168);
    get(0, 795, 22);
    get(1, 200, 150);
    get(0, 50, 200);
    send(1, 260, 240, 3, ok);
    chk("bp_acc4", ok, 1);
    send(1, 0, 0, 3, ok);
    chk("bp_acc5", ok, 1);
    get(1, 260, 240);
    get(0, 0, 0);
    send(1, 178, 168, 3, ok);
    chk("old_acc", ok, 1);
    send(0, 0, 0, 3, ok);
    chk("nv0", ok, 1);
    send(0, 100, 0, 3, ok);
    chk("nv1", ok, 1);
    send(0, 0, 100, 3, ok);
    chk("nv2", ok, 1);
    bus("reload_hold", 1, 178, 168);
    send(1, 10, 10, 3, ok);
    chk("nq_acc", ok, 1);
    bus("nburst_v0", 0, 0, 0);
    @(negedge clk);
    bus("nburst_v1", 0, 100, 0);
    @(negedge clk);
    bus("nburst_v2", 0, 0, 100);
    @(negedge clk);
    bus("nburst_q", 1, 10, 10);
    get(1, 178, 168);
    get(1, 10, 10);
    send(1, 90, 90, 3, ok);
    chk("q90_acc", ok, 1);
    get(0, 90, 90);
    send(1, 10, 10, 3, ok);
    chk("rq0_acc", ok, 1);
    send(1, 90, 90, 3, ok);
    chk("rq1_acc", ok, 1);
    repeat (6) @(negedge clk);
    chk("rq_queued", res_valid, 1);
    send(1, 50, 50, 3, ok);
    chk("rq2_acc", ok, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    bus("mid_rst", 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_res_valid", res_valid, 0);
    bus("post_rst", 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
